// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared types and constants for the multi-cycle MIPS control FSM
package mips_mc_pkg;

  // Controller states; encoding 4'd15 is unused and recovers to FETCH
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_ALU_WB_R  = 4'd4,
    S_EXEC_I    = 4'd5,
    S_ALU_WB_I  = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_READ  = 4'd8,
    S_MEM_WB    = 4'd9,
    S_MEM_WRITE = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_JAL       = 4'd13,
    S_JR        = 4'd14
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  // ALU operation classes handed to ALUControl
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ANDI  = 3'b010;
  localparam logic [2:0] ALU_ORI   = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  // Datapath mux selects
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic       SRC_A_PC = 1'b0;
  localparam logic       SRC_A_RS = 1'b1;

  localparam logic [1:0] SRC_B_RT     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  // State that follows DECODE; S_FETCH doubles as "unsupported opcode"
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_R:                             return (fn == FUNCT_JR) ? S_JR : S_EXEC_R;
      OP_LW, OP_SW:                     return S_MEM_ADDR;
      OP_BEQ, OP_BNE:                   return S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return S_EXEC_I;
      OP_J:                             return S_JUMP;
      OP_JAL:                           return S_JAL;
      default:                          return S_FETCH;
    endcase
  endfunction

  function automatic logic op_supported(input logic [5:0] op);
    return decode_next(op, 6'd0) != S_FETCH;
  endfunction

  // ALU class for the immediate-ALU instructions
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_ANDI;
      OP_ORI:  return ALU_ORI;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_output_decoder.sv
// rtl/multicycle_output_decoder.sv - combinational control-output map for the multi-cycle FSM
module multicycle_output_decoder
  import mips_mc_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        illegal_op
);

  // Moore decode of the state; only FETCH enables and the branch qualifier look at inputs
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PC_SRC_ALU;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RT;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WD_ALUOUT;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRC_B_IMM_SH;
        illegal_op = !op_supported(opcode);
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS;
        alu_op    = ALU_RTYPE;
      end
      S_ALU_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS;
        alu_src_b = SRC_B_IMM;
        alu_op    = imm_alu_op(opcode);
      end
      S_ALU_WB_I: reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WD_MDR;
      end
      S_MEM_WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RS;
        alu_op    = ALU_SUB;
        pc_source = PC_SRC_ALUOUT;
        pc_write  = (opcode == OP_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        pc_source = PC_SRC_JUMP;
        pc_write  = 1'b1;
      end
      S_JAL: begin
        pc_source  = PC_SRC_JUMP;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = DST_RA;
        mem_to_reg = WD_PC;
      end
      S_JR: begin
        pc_source = PC_SRC_RS;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle MIPS sequencing controller (state register and next-state)
module multicycle_control_fsm
  import mips_mc_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        illegal_op,
  output logic [3:0]  state_dbg
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  state_t     state;
  logic [3:0] hold_cnt;

  // State register, post-reset hold counter and next-state sequencing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= S_FETCH;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        S_FETCH:     if (mem_ready) state <= S_DECODE;
        S_DECODE:    state <= decode_next(opcode, funct);
        S_EXEC_R:    state <= S_ALU_WB_R;
        S_EXEC_I:    state <= S_ALU_WB_I;
        S_MEM_ADDR:  state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
        default:     state <= S_FETCH;
      endcase
    end
  end

  assign state_dbg = state;

  multicycle_output_decoder u_decoder (
    .state      (state),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
  import mips_mc_pkg::*;

  localparam int HOLD = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
  logic       alu_src_a, reg_write, illegal_op;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       illegal_op;
  } obs_t;

  obs_t       obs[$];
  int         n_cyc;
  logic [3:0] exp_st[$];
  int         n_pass = 0;
  int         n_total = 0;

  multicycle_control_fsm #(.RESET_PC_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return '{state_dbg, mem_req, mem_write, i_or_d, ir_write, pc_write, pc_source,
             alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op};
  endfunction

  // Runs one instruction from FETCH up to (not including) the next FETCH.
  // Entered and left at posedge+1. Stalls are placed on the memory handshake; elsewhere
  // mem_ready toggles randomly since the controller must ignore it there.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int sf, input int sm);
    int fs = sf;
    int ms = sm;
    bit left = 0;
    logic [3:0] st;
    obs.delete();
    opcode = op; funct = fn; zero = z;
    for (int c = 0; c < 64; c++) begin
      st = state_dbg;
      if (st != S_FETCH) left = 1;
      else if (left) break;
      if (st == S_FETCH) begin
        mem_ready = (fs == 0); if (fs > 0) fs--;
      end else if (st == S_MEM_READ || st == S_MEM_WRITE) begin
        mem_ready = (ms == 0); if (ms > 0) ms--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      obs.push_back(sample());
      @(posedge clk); #1;
    end
    n_cyc = obs.size();
    while (obs.size() < 16) obs.push_back('0);
  endtask

  // Reference: cycle budget from the latency table plus stalls
  function automatic int model_latency(logic [5:0] op, logic [5:0] fn, int sf, int sm);
    int base;
    case (op)
      OP_R:                             base = (fn == FUNCT_JR) ? 3 : 4;
      OP_LW:                            base = 5 + sm;
      OP_SW:                            base = 4 + sm;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: base = 4;
      OP_BEQ, OP_BNE, OP_J, OP_JAL:     base = 3;
      default:                          base = 2;
    endcase
    return base + sf;
  endfunction

  // Reference: the ordered list of states the instruction walks through
  task automatic model_states(logic [5:0] op, logic [5:0] fn, int sf, int sm);
    exp_st.delete();
    repeat (sf + 1) exp_st.push_back(S_FETCH);
    exp_st.push_back(S_DECODE);
    if (op == OP_R && fn == FUNCT_JR) exp_st.push_back(S_JR);
    else if (op == OP_R) begin exp_st.push_back(S_EXEC_R); exp_st.push_back(S_ALU_WB_R); end
    else if (op == OP_LW) begin
      exp_st.push_back(S_MEM_ADDR); repeat (sm + 1) exp_st.push_back(S_MEM_READ); exp_st.push_back(S_MEM_WB);
    end else if (op == OP_SW) begin
      exp_st.push_back(S_MEM_ADDR); repeat (sm + 1) exp_st.push_back(S_MEM_WRITE);
    end else if (op == OP_BEQ || op == OP_BNE) exp_st.push_back(S_BRANCH);
    else if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_LUI) begin
      exp_st.push_back(S_EXEC_I); exp_st.push_back(S_ALU_WB_I);
    end else if (op == OP_J) exp_st.push_back(S_JUMP);
    else if (op == OP_JAL) exp_st.push_back(S_JAL);
  endtask

  task automatic test_reset();
    int idle = 0;
    reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (sample() !== obs_t'('0)) $display("FAIL reset_outputs got %h want 0", sample());
    else n_pass++;
    @(posedge clk); #1 reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (state_dbg !== S_IDLE) break;
      idle++;
    end
    n_total++;
    if (idle != HOLD || state_dbg !== S_FETCH)
      $display("FAIL reset_hold idle=%0d state=%0d want idle=%0d state=%0d", idle, state_dbg, HOLD, S_FETCH);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    run_instr(OP_R, 6'h20, 1'b0, 0, 0);
    n_total++;
    if (n_cyc != 4) $display("FAIL rtype_len got %0d want 4", n_cyc); else n_pass++;
    n_total++;
    if ({obs[0].st, obs[1].st, obs[2].st, obs[3].st} !== {S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB_R})
      $display("FAIL rtype_states got %h", {obs[0].st, obs[1].st, obs[2].st, obs[3].st});
    else n_pass++;
    n_total++;
    if ({obs[0].reg_write, obs[1].reg_write, obs[2].reg_write, obs[3].reg_write, obs[3].reg_dst} !== 6'b0001_01)
      $display("FAIL rtype_wb got %b want 000101",
               {obs[0].reg_write, obs[1].reg_write, obs[2].reg_write, obs[3].reg_write, obs[3].reg_dst});
    else n_pass++;
    n_total++;
    if ({obs[2].alu_src_a, obs[2].alu_src_b, obs[2].alu_op, obs[1].alu_src_b, obs[0].alu_src_b} !== 12'b1_00_111_11_01)
      $display("FAIL rtype_alu got %b want 100111110 1", {obs[2].alu_src_a, obs[2].alu_src_b, obs[2].alu_op, obs[1].alu_src_b, obs[0].alu_src_b});
    else n_pass++;
  endtask

  task automatic test_lw_stall();
    run_instr(OP_LW, 6'h00, 1'b0, 0, 2);
    n_total++;
    if (n_cyc != 7) $display("FAIL lw_len got %0d want 7", n_cyc); else n_pass++;
    n_total++;
    if ({obs[3].st, obs[4].st, obs[5].st, obs[6].st} !== {S_MEM_READ, S_MEM_READ, S_MEM_READ, S_MEM_WB})
      $display("FAIL lw_states got %h", {obs[3].st, obs[4].st, obs[5].st, obs[6].st});
    else n_pass++;
    n_total++;
    if ({obs[3].mem_req, obs[3].i_or_d, obs[4].mem_req, obs[4].i_or_d, obs[5].mem_req, obs[5].i_or_d} !== 6'b111111)
      $display("FAIL lw_memreq got %b want 111111",
               {obs[3].mem_req, obs[3].i_or_d, obs[4].mem_req, obs[4].i_or_d, obs[5].mem_req, obs[5].i_or_d});
    else n_pass++;
    n_total++;
    if ({obs[6].reg_write, obs[6].mem_to_reg, obs[6].reg_dst} !== 5'b1_01_00)
      $display("FAIL lw_wb got %b want 10100", {obs[6].reg_write, obs[6].mem_to_reg, obs[6].reg_dst});
    else n_pass++;
  endtask

  task automatic test_branch();
    run_instr(OP_BEQ, 6'h00, 1'b1, 0, 0);
    n_total++;
    if (n_cyc != 3 || obs[2].st !== S_BRANCH || obs[2].pc_write !== 1'b1 || obs[2].pc_source !== 2'b01)
      $display("FAIL beq_taken len=%0d st=%0d pcw=%b src=%b want 3/%0d/1/01",
               n_cyc, obs[2].st, obs[2].pc_write, obs[2].pc_source, S_BRANCH);
    else n_pass++;
    run_instr(OP_BNE, 6'h00, 1'b1, 0, 0);
    n_total++;
    if (n_cyc != 3 || obs[2].st !== S_BRANCH || obs[2].pc_write !== 1'b0 || obs[2].alu_op !== ALU_SUB)
      $display("FAIL bne_not_taken len=%0d st=%0d pcw=%b op=%b want 3/%0d/0/001",
               n_cyc, obs[2].st, obs[2].pc_write, obs[2].alu_op, S_BRANCH);
    else n_pass++;
  endtask

  task automatic test_jal_jr();
    run_instr(OP_JAL, 6'h00, 1'b0, 0, 0);
    n_total++;
    if ({obs[2].st, obs[2].pc_write, obs[2].pc_source, obs[2].reg_write, obs[2].reg_dst, obs[2].mem_to_reg}
        !== {S_JAL, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10} || n_cyc != 3)
      $display("FAIL jal got st=%0d pcw=%b src=%b rw=%b dst=%b m2r=%b len=%0d", obs[2].st, obs[2].pc_write,
               obs[2].pc_source, obs[2].reg_write, obs[2].reg_dst, obs[2].mem_to_reg, n_cyc);
    else n_pass++;
    run_instr(OP_R, FUNCT_JR, 1'b0, 0, 0);
    n_total++;
    if ({obs[2].st, obs[2].pc_write, obs[2].pc_source, obs[2].reg_write} !== {S_JR, 1'b1, 2'b11, 1'b0} || n_cyc != 3)
      $display("FAIL jr got st=%0d pcw=%b src=%b rw=%b len=%0d", obs[2].st, obs[2].pc_write,
               obs[2].pc_source, obs[2].reg_write, n_cyc);
    else n_pass++;
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    n_total++;
    if (n_cyc != 2 || obs[1].st !== S_DECODE || {obs[0].illegal_op, obs[1].illegal_op} !== 2'b01)
      $display("FAIL illegal_pulse len=%0d st=%0d pulse=%b want 2/%0d/01", n_cyc, obs[1].st,
               {obs[0].illegal_op, obs[1].illegal_op}, S_DECODE);
    else n_pass++;
    n_total++;
    if ({obs[0].reg_write, obs[1].reg_write, obs[1].mem_req} !== 3'b000 || state_dbg !== S_FETCH)
      $display("FAIL illegal_quiet got rw/mreq=%b state=%0d want 000/%0d",
               {obs[0].reg_write, obs[1].reg_write, obs[1].mem_req}, state_dbg, S_FETCH);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] ops [14] = '{OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
                             OP_ANDI, OP_ORI, OP_LUI, OP_J, OP_JAL, 6'h3F, 6'h01};
    for (int k = 0; k < 60; k++) begin
      logic [5:0] op, fn;
      logic z;
      int sf, sm, bad;
      logic [12:0] e, o;
      op = ops[$urandom_range(0, 13)];
      fn = ($urandom_range(0, 3) == 0) ? FUNCT_JR : 6'($urandom_range(0, 63));
      z  = 1'($urandom_range(0, 1));
      sf = $urandom_range(0, 2);
      sm = $urandom_range(0, 2);
      run_instr(op, fn, z, sf, sm);
      model_states(op, fn, sf, sm);
      n_total++;
      if (n_cyc != model_latency(op, fn, sf, sm))
        $display("FAIL rand_len op=%h fn=%h sf=%0d sm=%0d got %0d want %0d", op, fn, sf, sm, n_cyc,
                 model_latency(op, fn, sf, sm));
      else n_pass++;
      bad = -1;
      for (int i = 0; i < exp_st.size(); i++) begin
        logic [3:0] s;
        s = exp_st[i];
        e = {s,
             s == S_FETCH || s == S_MEM_READ || s == S_MEM_WRITE,
             s == S_MEM_WRITE,
             s == S_MEM_READ || s == S_MEM_WRITE,
             s == S_FETCH && i == sf,
             (s == S_FETCH && i == sf) || s == S_JUMP || s == S_JAL || s == S_JR ||
               (s == S_BRANCH && (op == OP_BNE ? !z : z)),
             s == S_ALU_WB_R || s == S_ALU_WB_I || s == S_MEM_WB || s == S_JAL,
             s == S_DECODE && exp_st.size() == sf + 2};
        o = {obs[i].st, obs[i].mem_req, obs[i].mem_write, obs[i].i_or_d, obs[i].ir_write,
             obs[i].pc_write, obs[i].reg_write, obs[i].illegal_op};
        if (bad < 0 && (o !== e || i >= n_cyc)) bad = i;
      end
      n_total++;
      if (bad >= 0)
        $display("FAIL rand_cycle op=%h fn=%h z=%b sf=%0d sm=%0d cycle=%0d got %b want %b", op, fn, z, sf, sm,
                 bad, {obs[bad].st, obs[bad].mem_req, obs[bad].mem_write, obs[bad].i_or_d, obs[bad].ir_write,
                 obs[bad].pc_write, obs[bad].reg_write, obs[bad].illegal_op}, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_write();
    int idle = 0;
    opcode = OP_SW; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    for (int c = 0; c < 8 && state_dbg !== S_MEM_WRITE; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_total++;
    if ({state_dbg, mem_req, mem_write} !== {S_MEM_WRITE, 2'b11})
      $display("FAIL midwr_stall got st=%0d req/wr=%b%b want %0d/11", state_dbg, mem_req, mem_write, S_MEM_WRITE);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({state_dbg, mem_req, mem_write} !== {S_IDLE, 2'b00})
      $display("FAIL midwr_async got st=%0d req/wr=%b%b want 0/00", state_dbg, mem_req, mem_write);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    mem_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (state_dbg !== S_IDLE) break;
      idle++;
    end
    n_total++;
    if (idle != HOLD || state_dbg !== S_FETCH)
      $display("FAIL midwr_restart idle=%0d state=%0d want %0d/%0d", idle, state_dbg, HOLD, S_FETCH);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_jal_jr();
    test_illegal();
    test_random();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle variant of the MIPS core, replacing the single-cycle combinational control decode.
- Drives the shared ALU, the unified instruction/data memory port, IR, PC and register-file enables, one state per cycle.
- Waits on a memory-ready handshake so slow memories stall the sequence cleanly.
- Supports R-type (incl. jr), lw, sw, beq, bne, addi, andi, ori, lui, j, jal.

Parameters:
- RESET_PC_HOLD, 1, number of IDLE cycles after reset release before the first FETCH (1..15).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; IR is stable outside FETCH.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag from the current cycle.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  write qualifier for mem_req (0 = read).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC (already qualified for branches).
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = rs.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sext(imm), 11 = sext(imm)<<2.
- alu_op  out  3  ALU operation class for ALUControl.
- reg_write  out  1  register-file write enable.
- reg_dst  out  2  destination select: 00 = rt, 01 = rd, 10 = $31.
- mem_to_reg  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (reset=0, async): state=IDLE; every output 0; hold counter cleared.
- IDLE: count RESET_PC_HOLD cycles, then go to FETCH.
- Outputs are Moore-decoded from state. Exception: ir_write and pc_write in FETCH/MEM states are gated by mem_ready.
- FETCH
  - Drives mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay in FETCH with no enables.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes branch target). Next state by opcode:
  - R-type with funct=001000 -> JR.
  - Other R-type -> EXEC_R.
  - lw/sw -> MEM_ADDR.
  - beq/bne -> BRANCH.
  - addi/andi/ori/lui -> EXEC_I.
  - j -> JUMP.
  - jal -> JAL.
  - Anything else -> FETCH, with illegal_op=1 for that cycle.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=RTYPE; next ALU_WB_R.
- ALU_WB_R: reg_write=1, reg_dst=01, mem_to_reg=00; next FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op from opcode (ADDI/ANDI/ORI/LUI); next ALU_WB_I.
- ALU_WB_I: reg_write=1, reg_dst=00, mem_to_reg=00; next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD; lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_req=1, i_or_d=1; stays until mem_ready; then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; next FETCH.
- MEM_WRITE: mem_req=1, mem_write=1, i_or_d=1; stays until mem_ready; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01.
  - pc_write = zero for beq, ~zero for bne.
  - Next FETCH.
- JUMP: pc_source=10, pc_write=1; next FETCH.
- JAL: pc_source=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10 (PC already = PC+4); next FETCH.
- JR: pc_source=11, pc_write=1; next FETCH.
- Latency with zero wait states:
  - beq/bne/j/jal/jr: 3 cycles.
  - R-type, I-type ALU, sw: 4 cycles.
  - lw: 5 cycles.
  - Each stall cycle (mem_ready=0) adds 1.
- mem_ready is ignored outside FETCH/MEM_READ/MEM_WRITE.
- Reset asserted mid-access: immediate return to IDLE; mem_req drops asynchronously.
- Unused state encodings -> FETCH next cycle.

Decomposition:
- Package mips_mc_pkg holds:
  - the state enum (4-bit);
  - opcode constants (R, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, LUI, J, JAL);
  - FUNCT_JR;
  - alu_op codes: ADD=000, SUB=001, ANDI=010, ORI=011, LUI=100, RTYPE=111;
  - the mux-select constants.
- One sub-module, multicycle_output_decoder: a purely combinational map from (state, opcode, zero, mem_ready) to the control outputs. The top level keeps the state register, hold counter and next-state logic.

Test Plan:
- Reset release, RESET_PC_HOLD=1, mem_ready=1, opcode=000000 funct=100000 -> state sequence IDLE, FETCH, DECODE, EXEC_R, ALU_WB_R, FETCH; reg_write=1 with reg_dst=01 only in ALU_WB_R.
- lw (100011) with mem_ready held 0 for 2 cycles in MEM_READ -> MEM_READ lasts 3 cycles; mem_req=1, i_or_d=1 throughout; MEM_WB reg_write=1, mem_to_reg=01; total 7 cycles.
- beq with zero=1, then bne with zero=1 -> beq: BRANCH pc_write=1, pc_source=01; bne: pc_write=0; both take 3 cycles.
- jal (000011) -> JAL state: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10; R-type funct=001000 -> JR state with pc_source=11.
- opcode=111111 -> illegal_op pulses exactly 1 cycle in DECODE; next state FETCH; no reg_write or mem_req asserted.
- reset driven low during MEM_WRITE stall (mem_ready=0) -> mem_req and mem_write go 0 without a clock edge; state_dbg=IDLE; first FETCH occurs RESET_PC_HOLD cycles after release.
